cpu_8bit: RTL and testbench

Minimal multi-cycle 8-bit CPU core, module name `cpu_8bit`. It executes 32-bit instruction words from a program image presented as a flattened, read-only RAM bus. It exposes its architectural state (registers AL/BL/CL/DL, flags, IR, PC, FSM state and cycle counter) as outputs for observation at system level and in simulation.

---
 rtl/cpu_8bit.sv | 174 +++++++++++++++++
 tb/tb_cpu_8bit.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/cpu_8bit.sv
// Multi-cycle 8-bit CPU: FETCH/DECODE/EXECUTE over a flat read-only program bus.
// Define CPU_CLKS_EN to build the 16-bit cycle counter; otherwise clks reads zero.
module cpu_8bit #(
  parameter int RAM_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [RAM_SIZE*32-1:0]  ram,
  output logic [7:0]              flags,
  output logic [7:0]              al,
  output logic [7:0]              bl,
  output logic [7:0]              cl,
  output logic [7:0]              dl,
  output logic [31:0]             ir,
  output logic [15:0]             clks,
  output logic [7:0]              pc,
  output logic [1:0]              state
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [3:0][7:0] rf_q, rf_d;
  logic [3:0]      fl_q, fl_d;
  logic [31:0]     ir_q, ir_d;
  logic [7:0]      pc_q, pc_d;

  logic [7:0]  op, imm, a, b, res;
  logic [1:0]  dst, src;
  logic [8:0]  sum9;
  logic [7:0]  dif;
  logic        add_of, sub_of;
  logic        wr, take;
  logic [3:0]  fl_n;
  logic [31:0] fetch_word;
  logic        unused_ir;

  assign op  = ir_q[31:24];
  assign dst = ir_q[17:16];
  assign src = ir_q[9:8];
  assign imm = ir_q[7:0];
  assign unused_ir = ^{ir_q[23:18], ir_q[15:10]};

  // Out-of-range pc matches no word and fetches a NOP.
  always_comb begin
    fetch_word = 32'h0;
    for (int i = 0; i < RAM_SIZE; i++) begin
      if (pc_q == 8'(i)) fetch_word = ram[i*32 +: 32];
    end
  end

  always_comb begin
    a = rf_q[dst];
    b = imm;
    if (op >= 8'h18 && op <= 8'h1C) b = rf_q[src];
    if (op == 8'h30 || op == 8'h31) b = 8'd1;
  end

  assign sum9   = {1'b0, a} + {1'b0, b};
  assign dif    = a - b;
  assign add_of = (a[7] == b[7]) && (sum9[7] != a[7]);
  assign sub_of = (a[7] != b[7]) && (dif[7] != a[7]);

  // fl_n layout: {OF, SF, ZF, CF}
  always_comb begin
    res  = a;
    wr   = 1'b0;
    take = 1'b0;
    fl_n = fl_q;
    case (op)
      8'h01: begin res = imm; wr = 1'b1; end
      8'h02: begin res = rf_q[src]; wr = 1'b1; end
      8'h10, 8'h18, 8'h30: begin
        res  = sum9[7:0];
        wr   = 1'b1;
        fl_n = {add_of, res[7], res == 8'h0, sum9[8]};
      end
      8'h11, 8'h19, 8'h31, 8'h1F: begin
        res  = dif;
        wr   = (op != 8'h1F);
        fl_n = {sub_of, res[7], res == 8'h0, a < b};
      end
      8'h12, 8'h1A: begin
        res  = a & b;
        wr   = 1'b1;
        fl_n = {1'b0, res[7], res == 8'h0, 1'b0};
      end
      8'h13, 8'h1B: begin
        res  = a | b;
        wr   = 1'b1;
        fl_n = {1'b0, res[7], res == 8'h0, 1'b0};
      end
      8'h14, 8'h1C: begin
        res  = a ^ b;
        wr   = 1'b1;
        fl_n = {1'b0, res[7], res == 8'h0, 1'b0};
      end
      8'h20: take = 1'b1;
      8'h21: take = fl_q[1];
      8'h22: take = !fl_q[1];
      8'h23: take = fl_q[0];
      8'h24: take = !fl_q[0];
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rf_d    = rf_q;
    fl_d    = fl_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    case (state_q)
      S_FETCH: begin
        ir_d    = fetch_word;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (wr) rf_d[dst] = res;
        fl_d    = fl_n;
        pc_d    = take ? imm : pc_q + 8'd1;
        state_d = (op == 8'hFF) ? S_HALT : S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      rf_q    <= '0;
      fl_q    <= '0;
      ir_q    <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      rf_q    <= rf_d;
      fl_q    <= fl_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
    end
  end

`ifdef CPU_CLKS_EN
  logic [15:0] clks_q, clks_d;

  assign clks_d = (state_q != S_HALT) ? clks_q + 16'd1 : clks_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) clks_q <= '0;
    else        clks_q <= clks_d;
  end

  assign clks = clks_q;
`else
  assign clks = 16'h0000;
`endif

  assign flags = {4'h0, fl_q};
  assign al    = rf_q[0];
  assign bl    = rf_q[1];
  assign cl    = rf_q[2];
  assign dl    = rf_q[3];
  assign ir    = ir_q;
  assign pc    = pc_q;
  assign state = state_q;

endmodule

// File: tb/tb_cpu_8bit.sv
// Directed bench for cpu_8bit: hand-computed register, flag, pc and state values.
// A second instance with RAM_SIZE=2 covers out-of-range fetch and pc wrap.
module tb_cpu_8bit;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [127:0] ram = '0;
  logic [63:0]  ram2 = {32'h30000000, 32'h01000001};

  logic [7:0]  flags, al, bl, cl, dl, pc;
  logic [31:0] ir;
  logic [15:0] clks;
  logic [1:0]  state;

  logic [7:0]  flags2, al2, bl2, cl2, dl2, pc2;
  logic [31:0] ir2;
  logic [15:0] clks2;
  logic [1:0]  state2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cpu_8bit #(.RAM_SIZE(4)) u_dut (
    .clk(clk), .reset(reset), .ram(ram),
    .flags(flags), .al(al), .bl(bl), .cl(cl), .dl(dl),
    .ir(ir), .clks(clks), .pc(pc), .state(state)
  );

  cpu_8bit #(.RAM_SIZE(2)) u_dut2 (
    .clk(clk), .reset(reset), .ram(ram2),
    .flags(flags2), .al(al2), .bl(bl2), .cl(cl2), .dl(dl2),
    .ir(ir2), .clks(clks2), .pc(pc2), .state(state2)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [127:0] img);
    reset = 1'b0;
    ram   = img;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [15:0] exp_clks(input int n);
`ifdef CPU_CLKS_EN
    return 16'(n);
`else
    return 16'h0;
`endif
  endfunction

  initial begin
    @(negedge clk);
    chk("rst_al", al, 8'h00);
    chk("rst_flags", flags, 8'h00);
    chk("rst_ir", ir, 32'h0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_clks", clks, 16'h0);
    chk("rst_state", state, 2'd0);

    // ADD/SUB to zero then halt
    start({32'hFF000000, 32'h11000008, 32'h10000003, 32'h01000005});
    tick(3); chk("t1_mov_al", al, 8'h05);
    tick(3); chk("t1_add_al", al, 8'h08);
    chk("t1_add_fl", flags, 8'h00);
    tick(3); chk("t1_sub_al", al, 8'h00);
    chk("t1_sub_fl", flags, 8'h02);
    tick(3); chk("t1_halt", state, 2'd3);
    chk("t1_pc", pc, 8'h04);
    chk("t1_clks", clks, exp_clks(12));
    tick(5); chk("t1_hold_st", state, 2'd3);
    chk("t1_hold_pc", pc, 8'h04);
    chk("t1_hold_clks", clks, exp_clks(12));

    // ADD carry to zero
    start({32'h00000000, 32'hFF000000, 32'h10010001, 32'h010100FF});
    tick(6); chk("t2_bl", bl, 8'h00);
    chk("t2_fl", flags, 8'h03);
    tick(3); chk("t2_halt", state, 2'd3);

    // MOV reg,reg and an endless jump loop
    start({32'h00000000, 32'h20000001, 32'h02030200, 32'h01020007});
    tick(6); chk("t3_cl", cl, 8'h07);
    chk("t3_dl", dl, 8'h07);
    chk("t3_pc2", pc, 8'h02);
    tick(3); chk("t3_jmp_pc", pc, 8'h01);
    tick(3); chk("t3_loop_pc", pc, 8'h02);
    tick(3); chk("t3_loop_pc1", pc, 8'h01);
    chk("t3_not_halt", state, 2'd0);

    // Signed overflow then CMP
    start({32'hFF000000, 32'h1F000080, 32'h10000001, 32'h0100007F});
    tick(6); chk("t4_add_al", al, 8'h80);
    chk("t4_add_fl", flags, 8'h0C);
    tick(3); chk("t4_cmp_al", al, 8'h80);
    chk("t4_cmp_fl", flags, 8'h02);

    // Reset asserted during DECODE clears everything immediately
    start({32'hFF000000, 32'h11000008, 32'h10000003, 32'h01000005});
    tick(4); chk("t6_pre_st", state, 2'd1);
    chk("t6_pre_al", al, 8'h05);
    #2 reset = 1'b0;
    #1;
    chk("t6_al", al, 8'h00);
    chk("t6_flags", flags, 8'h00);
    chk("t6_ir", ir, 32'h0);
    chk("t6_pc", pc, 8'h00);
    chk("t6_state", state, 2'd0);
    chk("t6_clks", clks, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    tick(3); chk("t6_re_al", al, 8'h05);
    chk("t6_re_pc", pc, 8'h01);

    // Small image: NOPs past the end, pc wraps and the program reruns
    start('0);
    tick(6); chk("t5_inc_al", al2, 8'h02);
    chk("t5_inc_fl", flags2, 8'h00);
    tick(3); chk("t5_nop_ir", ir2, 32'h0);
    chk("t5_pc3", pc2, 8'h03);
    tick(253 * 3); chk("t5_wrap_pc", pc2, 8'h00);
    chk("t5_wrap_al", al2, 8'h02);
    chk("t5_clks", clks2, exp_clks(768));
    tick(3); chk("t5_rerun_mov", al2, 8'h01);
    tick(3); chk("t5_rerun_inc", al2, 8'h02);
    chk("t5_state", state2, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
